serial_tx_arbiter: RTL and testbench
====================================

SERIAL_TX_ARBITER -- requirements
Module: serial_tx_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- N_REQ, 4, number of requesters, 2..8.
- GAP_BITS, 1, extra idle-high bit times after each stop bit, 0..15.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, input, 1, clock.
- reset, input, 1, synchronous, active-high reset.
- req_valid, input, N_REQ, per-requester byte-available flag.
- req_data, input, 8*N_REQ, requester i byte at bits [8i+7:8i].
- req_ready, output, N_REQ, per-requester accept strobe; combinational.
- tx, output, 1, registered serial line; idle high.
- busy, output, 1, registered; high while a frame or gap is in progress.
- grant_id, output, clog2(N_REQ), registered; index of the last accepted requester.
- frame_done, output, 1, registered; one-cycle pulse.

Function
REQ-003 The block SHALL use the states IDLE, START, DATA, STOP and GAP, with transitions:
- IDLE->START on accept.
- START->DATA after 1 cycle.
- DATA->STOP after exactly 8 cycles.
- STOP->GAP if GAP_BITS>0, else STOP->IDLE.
- GAP->IDLE after GAP_BITS cycles.
REQ-004 Arbitration SHALL be round-robin: in IDLE the winner is the first i with req_valid[i]=1, searching from (last_grant+1) mod N_REQ upward with wrap-around.
REQ-005 req_ready[winner] SHALL be 1 only in IDLE with reset low; all other req_ready bits SHALL be 0. In every other state all req_ready bits SHALL be 0.
REQ-006 An accept SHALL occur at the clock edge where req_valid[i] and req_ready[i] are both 1. On accept the block SHALL:
- latch req_data byte i into the shift register;
- set grant_id and last_grant to i;
- move to START.
REQ-007 last_grant SHALL change only on accept; cycles in which no requester is valid SHALL leave it unchanged.
REQ-008 A requester MAY deassert req_valid at any time before accept; the block SHALL NOT accept or transmit anything for a requester with req_valid low.
REQ-009 tx SHALL be 0 for the one cycle the state is START.
REQ-010 In DATA, tx SHALL present the latched byte LSB first, one bit per cycle: bit 0 in the first DATA cycle through bit 7 in the eighth.
REQ-011 tx SHALL be 1 in STOP, GAP and IDLE.
REQ-012 The first START cycle SHALL be the cycle immediately after the accept edge (1-cycle latency).
REQ-013 frame_done SHALL be 1 for exactly the STOP cycle and 0 otherwise.
REQ-014 busy SHALL be 1 in START, DATA, STOP and GAP, and 0 in IDLE.
REQ-015 The DATA bit counter SHALL be 3 bits, cleared on entering DATA, with no wrap beyond 7.
REQ-016 req_valid or req_data changes while busy SHALL have no effect on the frame in progress.
REQ-017 With all requesters continuously valid, the line SHALL be high for exactly 2+GAP_BITS cycles between data bit 7 of one frame and the start bit of the next: STOP + GAP_BITS + the IDLE accept cycle.
REQ-018 Illegal state encodings SHALL return to IDLE on the next clock.

Reset
REQ-019 While reset is high at a clock edge, the next-cycle outputs SHALL be: tx=1, busy=0, frame_done=0, grant_id=0.
REQ-020 While reset is high at a clock edge, the internal state SHALL be set to: state IDLE, bit counter 0, last_grant=N_REQ-1 (requester 0 has first priority), shift register 0.
REQ-021 req_ready SHALL be all zero while reset is high.
REQ-022 Reset asserted mid-frame SHALL abort the frame: tx=1 on the following cycle, the latched byte is discarded, and no frame_done pulse is produced.

Verification
REQ-023 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Only req_valid[0] with byte 0xA5 -> tx over 10 cycles = 0,1,0,1,0,0,1,0,1,1; frame_done high on the 10th cycle; grant_id=0.
- All 4 requesters continuously valid from reset -> grant order 0,1,2,3,0; each req_ready pulses once per accept.
- Last grant=2, then req_valid[1] and req_valid[3] asserted together -> 3 granted before 1.
- Reset asserted during data bit 4 -> next cycle tx=1, busy=0, frame_done=0; with req_valid[0] held, the next accept goes to requester 0.
- GAP_BITS=0 and GAP_BITS=3, back-to-back frames -> tx high for exactly 2 and 5 cycles respectively between data bit 7 and the next start bit.
- req_valid[2] pulsed high for one cycle while busy, then dropped -> no accept, tx stays 1 after the current frame, busy=0.

Source files
------------

// File: rtl/serial_tx_arbiter.sv
// ----------------------------------------------------------------------------
// serial_tx_arbiter
//
// Round-robin arbiter in front of a UART-style serial transmitter. While idle
// it grants one of N_REQ requesters, latches that requester's byte and sends
// it on tx as a frame: one start bit (0), eight data bits LSB first, and one
// stop bit (1). GAP_BITS extra idle-high bit times follow each stop bit. Each
// bit lasts one clock cycle.
//
// Ports
//   clk        : clock
//   reset      : synchronous, active-high reset
//   req_valid  : [N_REQ]   per-requester byte-available flag
//   req_data   : [8*N_REQ] requester i byte at bits [8i+7:8i]
//   req_ready  : [N_REQ]   accept strobe to the round-robin winner
//                          (combinational, asserted only when idle)
//   tx         : registered serial line, idle high
//   busy       : registered, high while a frame or gap is in progress
//   grant_id   : registered index of the last accepted requester
//   frame_done : registered one-cycle pulse during the stop bit
// ----------------------------------------------------------------------------
module serial_tx_arbiter #(
   parameter  int N_REQ    = 4,
   parameter  int GAP_BITS = 1,
   localparam int GW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [8*N_REQ-1:0] req_data,
   output logic [N_REQ-1:0]   req_ready,
   output logic               tx,
   output logic               busy,
   output logic [GW-1:0]      grant_id,
   output logic               frame_done
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      GAP   = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [3:0]    gap_cnt_q, gap_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic [GW-1:0] last_grant_q, last_grant_d;
   logic [GW-1:0] grant_id_q, grant_id_d;
   logic          tx_q, tx_d;
   logic          busy_q, busy_d;
   logic          frame_done_q, frame_done_d;

   logic             win_found_s;
   logic [GW-1:0]    win_idx_s;
   logic [GW-1:0]    cand_s;
   logic [N_REQ-1:0] req_ready_s;
   logic             accept_s;

   // Round-robin search: first valid requester after last_grant, wrapping.
   always_comb begin
      win_found_s = 1'b0;
      win_idx_s   = '0;
      cand_s      = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand_s = GW'((int'(last_grant_q) + k) % N_REQ);
         if (!win_found_s && req_valid[cand_s]) begin
            win_found_s = 1'b1;
            win_idx_s   = cand_s;
         end else begin
            win_found_s = win_found_s;
         end
      end
   end

   // Ready strobe to the winner only while idle and out of reset.
   always_comb begin
      req_ready_s = '0;
      if ((state_q == IDLE) && !reset && win_found_s) begin
         req_ready_s[win_idx_s] = 1'b1;
      end else begin
         req_ready_s = '0;
      end
   end

   assign accept_s  = |(req_valid & req_ready_s);
   assign req_ready = req_ready_s;

   // Next-state, datapath and registered-output computation.
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      shift_d      = shift_q;
      last_grant_d = last_grant_q;
      grant_id_d   = grant_id_q;

      case (state_q)
         IDLE: begin
            if (accept_s) begin
               shift_d      = req_data[{win_idx_s, 3'b000} +: 8];
               last_grant_d = win_idx_s;
               grant_id_d   = win_idx_s;
               state_d      = START;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            bit_cnt_d = 3'd0;
            state_d   = DATA;
         end
         DATA: begin
            if (bit_cnt_q == 3'd7) begin
               state_d = STOP;
            end else begin
               // Shift so that shift_d[0] is the bit shown in the next cycle.
               bit_cnt_d = bit_cnt_q + 3'd1;
               shift_d   = {1'b0, shift_q[7:1]};
            end
         end
         STOP: begin
            if (GAP_BITS > 0) begin
               gap_cnt_d = 4'd0;
               state_d   = GAP;
            end else begin
               state_d = IDLE;
            end
         end
         GAP: begin
            if (gap_cnt_q == 4'(GAP_BITS - 1)) begin
               state_d = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are registered from the next state so they align with state_q.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
      busy_d       = (state_d != IDLE);
      frame_done_d = (state_d == STOP);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         bit_cnt_q    <= 3'd0;
         gap_cnt_q    <= 4'd0;
         shift_q      <= 8'd0;
         last_grant_q <= GW'(N_REQ - 1);
         grant_id_q   <= '0;
         tx_q         <= 1'b1;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         shift_q      <= shift_d;
         last_grant_q <= last_grant_d;
         grant_id_q   <= grant_id_d;
         tx_q         <= tx_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign tx         = tx_q;
   assign busy       = busy_q;
   assign grant_id   = grant_id_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// ----------------------------------------------------------------------------
// Self-checking bench for serial_tx_arbiter. Three instances share the
// inputs: the main one (GAP_BITS=1) plus GAP_BITS=0 and GAP_BITS=3 copies used
// for the inter-frame gap measurement. Outputs are sampled on the falling
// edge; inputs are driven on the falling edge.
// ----------------------------------------------------------------------------
module tb_serial_tx_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [31:0] req_data;

   logic [3:0]  req_ready_m, req_ready_g0, req_ready_g3;
   logic        tx_m, tx_g0, tx_g3;
   logic        busy_m, busy_g0, busy_g3;
   logic [1:0]  grant_m, grant_g0, grant_g3;
   logic        done_m, done_g0, done_g3;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   serial_tx_arbiter #(.N_REQ(4), .GAP_BITS(1)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready_m), .tx(tx_m), .busy(busy_m),
      .grant_id(grant_m), .frame_done(done_m));

   serial_tx_arbiter #(.N_REQ(4), .GAP_BITS(0)) dut_g0 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready_g0), .tx(tx_g0), .busy(busy_g0),
      .grant_id(grant_g0), .frame_done(done_g0));

   serial_tx_arbiter #(.N_REQ(4), .GAP_BITS(3)) dut_g3 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready_g3), .tx(tx_g3), .busy(busy_g3),
      .grant_id(grant_g3), .frame_done(done_g3));

   function automatic logic get_tx(input int k);
      if (k == 0) return tx_m;
      else if (k == 1) return tx_g0;
      else return tx_g3;
   endfunction

   // Hold reset for two edges; return at a falling edge with reset released.
   task automatic do_reset();
      reset     = 1'b1;
      req_valid = 4'd0;
      req_data  = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      req_valid = 4'hF;
      req_data  = $urandom;
      @(posedge clk);
      @(negedge clk);
      checks++; if (tx_m !== 1'b1) begin failures++; $display("FAIL reset_tx: got %0b expected 1", tx_m); end
      checks++; if (busy_m !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy_m); end
      checks++; if (done_m !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b expected 0", done_m); end
      checks++; if (grant_m !== 2'd0) begin failures++; $display("FAIL reset_grant: got %0d expected 0", grant_m); end
      checks++; if (req_ready_m !== 4'b0000) begin failures++; $display("FAIL reset_ready: got %b expected 0000", req_ready_m); end
      reset = 1'b0;
      #1;
      checks++; if (req_ready_m !== 4'b0001) begin failures++; $display("FAIL reset_first_prio: got %b expected 0001", req_ready_m); end
      req_valid = 4'd0;
   endtask

   task automatic test_single_a5();
      logic [9:0] exp_bits;
      exp_bits = 10'b1101001010; // cycle 0 in bit 0: 0,1,0,1,0,0,1,0,1,1
      do_reset();
      req_valid = 4'b0001;
      req_data  = 32'h5A3C_96A5;
      #1;
      checks++; if (req_ready_m !== 4'b0001) begin failures++; $display("FAIL a5_ready: got %b expected 0001", req_ready_m); end
      @(negedge clk);
      req_valid = 4'd0;
      for (int c = 0; c < 10; c++) begin
         if (c > 0) @(negedge clk);
         checks++; if (tx_m !== exp_bits[c]) begin failures++; $display("FAIL a5_tx[%0d]: got %0b expected %0b", c, tx_m, exp_bits[c]); end
         checks++; if (done_m !== (c == 9)) begin failures++; $display("FAIL a5_done[%0d]: got %0b expected %0b", c, done_m, (c == 9)); end
         checks++; if (busy_m !== 1'b1) begin failures++; $display("FAIL a5_busy[%0d]: got %0b expected 1", c, busy_m); end
      end
      checks++; if (grant_m !== 2'd0) begin failures++; $display("FAIL a5_grant: got %0d expected 0", grant_m); end
   endtask

   task automatic test_round_robin();
      int exp_order[5] = '{0, 1, 2, 3, 0};
      int got = 0;
      int cyc = 0;
      int idx;
      logic prev_ready = 1'b0;
      int pend = -1;
      do_reset();
      req_valid = 4'hF;
      req_data  = $urandom;
      while (got < 5 && cyc < 200) begin
         if (pend >= 0) begin
            checks++; if (grant_m !== 2'(pend)) begin failures++; $display("FAIL rr_grant_id: got %0d expected %0d", grant_m, pend); end
            pend = -1;
         end
         #1;
         if (req_ready_m !== 4'b0000) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (req_ready_m[i]) idx = i;
            checks++; if (!$onehot(req_ready_m)) begin failures++; $display("FAIL rr_onehot: got %b expected one-hot", req_ready_m); end
            checks++; if (idx != exp_order[got]) begin failures++; $display("FAIL rr_order[%0d]: got %0d expected %0d", got, idx, exp_order[got]); end
            checks++; if (prev_ready !== 1'b0) begin failures++; $display("FAIL rr_single_pulse: got ready two cycles in a row expected one"); end
            pend = idx;
            got++;
            prev_ready = 1'b1;
         end else begin
            prev_ready = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      checks++; if (got != 5) begin failures++; $display("FAIL rr_timeout: got %0d accepts expected 5", got); end
      req_valid = 4'd0;
   endtask

   task automatic test_priority();
      int n;
      do_reset();
      req_valid = 4'b0100;
      req_data  = $urandom;
      #1;
      checks++; if (req_ready_m !== 4'b0100) begin failures++; $display("FAIL prio_first: got %b expected 0100", req_ready_m); end
      @(negedge clk);
      req_valid = 4'd0;
      n = 0;
      while (busy_m && n < 40) begin @(negedge clk); n++; end
      checks++; if (busy_m !== 1'b0) begin failures++; $display("FAIL prio_idle1_timeout: got busy %0b expected 0", busy_m); end
      req_valid = 4'b1010;
      #1;
      checks++; if (req_ready_m !== 4'b1000) begin failures++; $display("FAIL prio_3_before_1: got %b expected 1000", req_ready_m); end
      @(negedge clk);
      req_valid = 4'b0010;
      n = 0;
      while (busy_m && n < 40) begin @(negedge clk); n++; end
      #1;
      checks++; if (req_ready_m !== 4'b0010) begin failures++; $display("FAIL prio_then_1: got %b expected 0010", req_ready_m); end
      @(negedge clk);
      req_valid = 4'd0;
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] b0;
      do_reset();
      req_valid = 4'b0011;
      req_data  = $urandom;
      b0 = req_data[7:0];
      #1;
      checks++; if (req_ready_m !== 4'b0001) begin failures++; $display("FAIL mid_first: got %b expected 0001", req_ready_m); end
      @(negedge clk);          // start bit
      repeat (5) @(negedge clk); // data bit 4
      checks++; if (tx_m !== b0[4]) begin failures++; $display("FAIL mid_bit4: got %0b expected %0b", tx_m, b0[4]); end
      reset = 1'b1;
      #1;
      checks++; if (req_ready_m !== 4'b0000) begin failures++; $display("FAIL mid_ready_in_reset: got %b expected 0000", req_ready_m); end
      @(negedge clk);
      checks++; if (tx_m !== 1'b1) begin failures++; $display("FAIL mid_tx: got %0b expected 1", tx_m); end
      checks++; if (busy_m !== 1'b0) begin failures++; $display("FAIL mid_busy: got %0b expected 0", busy_m); end
      checks++; if (done_m !== 1'b0) begin failures++; $display("FAIL mid_done: got %0b expected 0", done_m); end
      reset = 1'b0;
      #1;
      checks++; if (req_ready_m !== 4'b0001) begin failures++; $display("FAIL mid_next_grant0: got %b expected 0001", req_ready_m); end
      @(negedge clk);
      req_valid = 4'd0;
      repeat (12) @(negedge clk);
   endtask

   task automatic test_gap();
      int gaps[3] = '{1, 0, 3};
      int n;
      int highs;
      for (int k = 0; k < 3; k++) begin
         do_reset();
         req_data  = 32'd0;   // all-zero bytes: the only high run is the gap
         req_valid = 4'hF;
         n = 0;
         while (get_tx(k) !== 1'b0 && n < 20) begin @(negedge clk); n++; end
         while (get_tx(k) !== 1'b1 && n < 40) begin @(negedge clk); n++; end
         highs = 0;
         while (get_tx(k) === 1'b1 && n < 60) begin highs++; @(negedge clk); n++; end
         checks++; if (highs != 2 + gaps[k]) begin failures++; $display("FAIL gap_%0d_high_run: got %0d expected %0d", gaps[k], highs, 2 + gaps[k]); end
         req_valid = 4'd0;
      end
   endtask

   task automatic test_glitch_while_busy();
      int n;
      do_reset();
      req_valid = 4'b0001;
      req_data  = $urandom;
      @(negedge clk);
      req_valid = 4'd0;
      repeat (3) @(negedge clk);
      req_valid = 4'b0100;
      #1;
      checks++; if (req_ready_m !== 4'b0000) begin failures++; $display("FAIL glitch_ready_busy: got %b expected 0000", req_ready_m); end
      @(negedge clk);
      req_valid = 4'd0;
      n = 0;
      while (busy_m && n < 40) begin @(negedge clk); n++; end
      for (int c = 0; c < 5; c++) begin
         checks++; if (tx_m !== 1'b1 || busy_m !== 1'b0) begin failures++; $display("FAIL glitch_idle[%0d]: got tx=%0b busy=%0b expected tx=1 busy=0", c, tx_m, busy_m); end
         checks++; if (grant_m !== 2'd0) begin failures++; $display("FAIL glitch_grant[%0d]: got %0d expected 0", c, grant_m); end
         #1;
         checks++; if (req_ready_m !== 4'b0000) begin failures++; $display("FAIL glitch_ready[%0d]: got %b expected 0000", c, req_ready_m); end
         @(negedge clk);
      end
   endtask

   // Random traffic against a frame-queue model: each accept appends the whole
   // expected frame (tx, busy, frame_done per cycle) to a queue.
   task automatic test_random();
      logic [2:0] q[$];
      logic [2:0] cur;
      logic       idle;
      logic       rst_now;
      int         lg = 3;
      int         gid = 0;
      int         w;
      int         idx;
      logic [3:0] exp_ready;
      logic [7:0] byte_v;
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         idle = (q.size() == 0);
         cur  = idle ? 3'b100 : q.pop_front();
         checks++; if ({tx_m, busy_m, done_m} !== cur) begin failures++; $display("FAIL rand_out[%0d]: got tx/busy/done=%b expected %b", cyc, {tx_m, busy_m, done_m}, cur); end
         checks++; if (grant_m !== 2'(gid)) begin failures++; $display("FAIL rand_grant[%0d]: got %0d expected %0d", cyc, grant_m, gid); end
         rst_now = ($urandom_range(499) == 0);
         reset   = rst_now;
         for (int i = 0; i < 4; i++) if ($urandom_range(3) == 0) req_valid[i] = ~req_valid[i];
         req_data = $urandom;
         #1;
         exp_ready = 4'd0;
         w = -1;
         if (idle && !rst_now) begin
            for (int k = 1; k <= 4; k++) begin
               idx = (lg + k) % 4;
               if (w < 0 && req_valid[idx]) w = idx;
            end
         end
         if (w >= 0) exp_ready[w] = 1'b1;
         checks++; if (req_ready_m !== exp_ready) begin failures++; $display("FAIL rand_ready[%0d]: got %b expected %b", cyc, req_ready_m, exp_ready); end
         if (rst_now) begin
            q.delete();
            lg  = 3;
            gid = 0;
         end else if (w >= 0) begin
            byte_v = req_data[w*8 +: 8];
            q.push_back(3'b010);
            for (int b = 0; b < 8; b++) q.push_back({byte_v[b], 2'b10});
            q.push_back(3'b111);
            q.push_back(3'b110);   // one gap bit in the main instance
            lg  = w;
            gid = w;
         end
         @(negedge clk);
      end
      reset     = 1'b0;
      req_valid = 4'd0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      reset     = 1'b1;
      req_valid = 4'd0;
      req_data  = 32'd0;
      @(negedge clk);
      test_reset();
      test_single_a5();
      test_round_robin();
      test_priority();
      test_reset_mid_frame();
      test_gap();
      test_glitch_while_busy();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
